// File: rtl/dca_step_sequencer_pkg.sv
// Shared definitions for the DCA step sequencer: geometry, instruction layout,
// opcode bit positions, FSM encoding and the buffered command record.
package dca_step_sequencer_pkg;

  localparam int MATRIX_SIZE_PARA      = 8;
  localparam int MATRIX_NUM_ROW        = MATRIX_SIZE_PARA;
  localparam int MATRIX_NUM_COL        = MATRIX_SIZE_PARA;
  localparam int BW_NUM_STEP           = 16;
  localparam int DEF_CMD_FIFO_DEPTH    = 2;

  // Opcode bit positions, matching the step controller's decoder
  localparam int OPC_IDX_NO_CAL        = 0;
  localparam int OPC_IDX_LSU0_REQ      = 1;
  localparam int OPC_IDX_LSU1_REQ      = 2;
  localparam int OPC_IDX_LSU2_REQ      = 3;
  localparam int OPC_IDX_LOAD_ACC      = 4;
  localparam int BW_OPCODE             = 5;

  // inst = {row_mask, col_mask, last, opcode}
  localparam int BW_BLOCKED_STEP_INST  = MATRIX_NUM_ROW + MATRIX_NUM_COL + 1 + BW_OPCODE;

  localparam logic [BW_OPCODE-1:0] OPC_STEP_DEFAULT =
    (5'd1 << OPC_IDX_LSU0_REQ) | (5'd1 << OPC_IDX_LSU1_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [BW_NUM_STEP-1:0]    num_step;
    logic [MATRIX_NUM_ROW-1:0] row_mask;
    logic [MATRIX_NUM_COL-1:0] col_mask;
    logic                      load_acc;
    logic                      store;
  } cmd_t;

  localparam int BW_CMD = $bits(cmd_t);

  function automatic logic [BW_OPCODE-1:0] build_opcode(
    input logic load_acc,
    input logic store,
    input logic first,
    input logic last
  );
    logic [BW_OPCODE-1:0] op;
    op                   = OPC_STEP_DEFAULT;
    op[OPC_IDX_NO_CAL]   = 1'b0;
    op[OPC_IDX_LOAD_ACC] = load_acc & first;
    op[OPC_IDX_LSU2_REQ] = store & last;
    return op;
  endfunction

endpackage

// File: rtl/dca_step_sequencer_if.sv
// Command and instruction handshakes of the step sequencer.
// The sequencer is the slave: it accepts commands and offers instructions.
interface dca_step_sequencer_if;
  import dca_step_sequencer_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [BW_NUM_STEP-1:0]    cmd_num_step;
  logic [MATRIX_NUM_ROW-1:0] cmd_row_mask;
  logic [MATRIX_NUM_COL-1:0] cmd_col_mask;
  logic                      cmd_load_acc;
  logic                      cmd_store;

  logic                            inst_valid;
  logic                            inst_ready;
  logic [BW_BLOCKED_STEP_INST-1:0] inst;

  modport master (
    output cmd_valid, cmd_num_step, cmd_row_mask, cmd_col_mask, cmd_load_acc, cmd_store,
    output inst_ready,
    input  cmd_ready, inst_valid, inst
  );

  modport slave (
    input  cmd_valid, cmd_num_step, cmd_row_mask, cmd_col_mask, cmd_load_acc, cmd_store,
    input  inst_ready,
    output cmd_ready, inst_valid, inst
  );
endinterface

// File: rtl/dca_step_sequencer_cmd_fifo.sv
// Small synchronous command FIFO; ready and empty come straight from flops
// so nothing combinational reaches the command source.
module dca_step_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push = i_push & ~r_full & ~i_clear;
  assign w_pop  = i_pop & ~r_empty & ~i_clear;

  // occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // pointers and registered full/empty flags
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // storage array
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_ready = ~r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/dca_step_sequencer.sv
// Expands buffered tile commands into blocked-step instructions, waits for the
// step controller to go idle after the last one, then pulses done.
module dca_step_sequencer
  import dca_step_sequencer_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH = DEF_CMD_FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  dca_step_sequencer_if.slave    io_bus,
  input  logic                   i_ctrl_busy,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [BW_NUM_STEP-1:0] o_step_idx
);
  localparam logic [BW_NUM_STEP-1:0] STEP_ONE = 16'd1;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [BW_NUM_STEP-1:0]    r_num_step;
  logic [MATRIX_NUM_ROW-1:0] r_row_mask;
  logic [MATRIX_NUM_COL-1:0] r_col_mask;
  logic                      r_load_acc;
  logic                      r_store;
  logic [BW_NUM_STEP-1:0]    r_step_idx;

  cmd_t w_fifo_wdata;
  cmd_t w_fifo_rdata;
  logic w_fifo_empty;
  logic w_fifo_ready;
  logic w_pop;
  logic w_hs;
  logic w_last;

  assign w_fifo_wdata = {io_bus.cmd_num_step, io_bus.cmd_row_mask, io_bus.cmd_col_mask,
                         io_bus.cmd_load_acc, io_bus.cmd_store};

  dca_step_cmd_fifo #(
    .WIDTH (BW_CMD),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_push  (io_bus.cmd_valid),
    .i_wdata (w_fifo_wdata),
    .o_ready (w_fifo_ready),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty)
  );

  assign w_hs   = (r_state == ST_ISSUE) & io_bus.inst_ready;
  assign w_last = (r_step_idx == (r_num_step - STEP_ONE));

  // next-state logic; clear overrides every handshake
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_pop       = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = (w_fifo_rdata.num_step == '0) ? ST_DONE : ST_ISSUE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ISSUE: w_state_nxt = (w_hs && w_last) ? ST_DRAIN : ST_ISSUE;
        ST_DRAIN: w_state_nxt = i_ctrl_busy ? ST_DRAIN : ST_DONE;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // command registers and step counter (counter never passes num_step-1)
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_num_step <= '0;
      r_row_mask <= '0;
      r_col_mask <= '0;
      r_load_acc <= 1'b0;
      r_store    <= 1'b0;
      r_step_idx <= '0;
    end else if (w_pop) begin
      r_num_step <= w_fifo_rdata.num_step;
      r_row_mask <= w_fifo_rdata.row_mask;
      r_col_mask <= w_fifo_rdata.col_mask;
      r_load_acc <= w_fifo_rdata.load_acc;
      r_store    <= w_fifo_rdata.store;
      r_step_idx <= '0;
    end else if (w_hs && !w_last) begin
      r_step_idx <= r_step_idx + STEP_ONE;
    end
  end

  assign io_bus.cmd_ready  = w_fifo_ready;
  assign io_bus.inst_valid = (r_state == ST_ISSUE);
  assign io_bus.inst       = {r_row_mask, r_col_mask, w_last,
                              build_opcode(r_load_acc, r_store, (r_step_idx == '0), w_last)};
  assign o_done            = (r_state == ST_DONE);
  assign o_busy            = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign o_step_idx        = r_step_idx;
endmodule

// File: tb/tb_dca_step_sequencer.sv
// Directed bench for dca_step_sequencer: expected instructions are queued when
// a command is issued and a negedge monitor pops and compares on each handshake.
module tb_dca_step_sequencer;
  import dca_step_sequencer_pkg::*;

  localparam int BW_INST = BW_BLOCKED_STEP_INST;
  localparam int BW_EXP  = BW_NUM_STEP + BW_INST;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clear;
  logic                   ctrl_busy;
  logic                   busy;
  logic                   done;
  logic [BW_NUM_STEP-1:0] step_idx;

  dca_step_sequencer_if bus ();

  dca_step_sequencer #(.CMD_FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .io_bus      (bus),
    .i_ctrl_busy (ctrl_busy),
    .o_busy      (busy),
    .o_done      (done),
    .o_step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  logic [BW_EXP-1:0] exp_q[$];
  logic              stall_pend = 1'b0;
  logic [BW_EXP-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Opcode bits: [0]NO_CAL [1]LSU0 [2]LSU1 [3]LSU2 [4]LOAD_ACC
  function automatic logic [BW_INST-1:0] model_inst(input logic [7:0] row, input logic [7:0] col,
                                                     input logic la, input logic st,
                                                     input logic [15:0] idx, input logic [15:0] num);
    logic       last;
    logic [4:0] op;
    last = (idx == num - 16'd1);
    op   = 5'b00110;
    if (la && idx == 16'd0) op = op | 5'b10000;
    if (st && last)         op = op | 5'b01000;
    return {row, col, last, op};
  endfunction

  task automatic push_cmd(input logic [15:0] num, input logic [7:0] row, input logic [7:0] col,
                          input logic la, input logic st);
    int waited;
    for (int i = 0; i < int'(num); i++) begin
      logic [15:0] idx;
      idx = i[15:0];
      exp_q.push_back({idx, model_inst(row, col, la, st, idx, num)});
    end
    bus.cmd_valid    = 1'b1;
    bus.cmd_num_step = num;
    bus.cmd_row_mask = row;
    bus.cmd_col_mask = col;
    bus.cmd_load_acc = la;
    bus.cmd_store    = st;
    waited = 0;
    while (!bus.cmd_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", waited);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 500; i++) begin
      if (done_cnt >= target) break;
      @(posedge clk); #1;
    end
    check(name, done_cnt, target);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (clear) begin
        stall_pend = 1'b0;
      end else if (bus.inst_valid) begin
        if (stall_pend) check("stall_hold", {step_idx, bus.inst}, held);
        if (bus.inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_inst: got 0x%0h expected none", {step_idx, bus.inst});
          end else begin
            logic [BW_EXP-1:0] e;
            e = exp_q.pop_front();
            check("inst", {step_idx, bus.inst}, e);
          end
          stall_pend = 1'b0;
        end else begin
          stall_pend = 1'b1;
          held       = {step_idx, bus.inst};
        end
      end else begin
        if (stall_pend) begin
          checks++; failures++;
          $display("FAIL valid_drop: inst_valid got 0 expected 1 while stalled");
        end
        stall_pend = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; ctrl_busy = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_num_step = '0; bus.cmd_row_mask = '0;
    bus.cmd_col_mask = '0; bus.cmd_load_acc = 1'b0; bus.cmd_store = 1'b0;
    bus.inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_step_idx", step_idx, 16'd0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;

    // 1) three steps, done one cycle after ctrl_busy falls
    ctrl_busy = 1'b1;
    bus.inst_ready = 1'b1;
    push_cmd(16'd3, 8'hA5, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("t1_all_issued", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
    check("t1_drain_no_done", done_cnt, 0);
    check("t1_drain_busy", busy, 1'b1);
    ctrl_busy = 1'b0;
    @(negedge clk); check("t1_done_not_yet", done, 1'b0);
    @(negedge clk); check("t1_done_pulse", done, 1'b1);
    @(negedge clk); check("t1_done_one_cycle", done, 1'b0);
    @(posedge clk); #1;
    check("t1_done_cnt", done_cnt, 1);

    // 2) single-step command
    push_cmd(16'd1, 8'h81, 8'h7E, 1'b1, 1'b1);
    wait_done(2, "t2_done_cnt");
    check("t2_all_issued", exp_q.size(), 0);

    // 3) empty command
    push_cmd(16'd0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    check("t3_busy_c1", busy, 1'b1);
    check("t3_done_c1", done, 1'b0);
    @(negedge clk);
    check("t3_done_c2", done, 1'b1);
    check("t3_busy_c2", busy, 1'b1);
    check("t3_no_valid", bus.inst_valid, 1'b0);
    @(negedge clk);
    check("t3_done_c3", done, 1'b0);
    check("t3_busy_c3", busy, 1'b0);
    @(posedge clk); #1;
    check("t3_done_cnt", done_cnt, 3);

    // 4) random back-pressure
    bus.inst_ready = 1'b0;
    push_cmd(16'd6, 8'h0F, 8'hF0, 1'b0, 1'b1);
    for (int i = 0; i < 600 && done_cnt < 4; i++) begin
      bus.inst_ready = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
    end
    bus.inst_ready = 1'b1;
    check("t4_done_cnt", done_cnt, 4);
    check("t4_all_issued", exp_q.size(), 0);

    // 5) three back-to-back commands into a two-deep FIFO
    bus.inst_ready = 1'b0;
    push_cmd(16'd2, 8'h11, 8'h22, 1'b1, 1'b0);
    push_cmd(16'd1, 8'h33, 8'h44, 1'b0, 1'b1);
    push_cmd(16'd1, 8'h55, 8'h66, 1'b1, 1'b1);
    check("t5_ready_low", bus.cmd_ready, 1'b0);
    check("t5_busy", busy, 1'b1);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    check("t5_ready_back", bus.cmd_ready, 1'b1);
    check("t5_first_done", done_cnt, 5);
    wait_done(7, "t5_done_cnt");
    check("t5_all_issued", exp_q.size(), 0);

    // 6) clear during step 2 of 5 with a second command queued
    bus.inst_ready = 1'b1;
    push_cmd(16'd5, 8'h99, 8'h66, 1'b1, 1'b1);
    push_cmd(16'd1, 8'h12, 8'h34, 1'b1, 1'b1);
    for (int i = 0; i < 50 && !(step_idx == 16'd2 && bus.inst_valid); i++) begin
      @(posedge clk); #1;
    end
    check("t6_reached_step2", step_idx, 16'd2);
    bus.inst_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_valid_dropped", bus.inst_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_cmd_ready", bus.cmd_ready, 1'b1);
    check("t6_step_idx", step_idx, 16'd0);
    bus.inst_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, 7);
    check("t6_stays_idle", bus.inst_valid, 1'b0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
